// File: rtl/vga_sync_gen_if.sv
// Signal bundle between the horizontal pixel counter and the VGA sync stage.
// The sync stage connects through the slave modport. Whoever drives the
// horizontal count, and reads the timing outputs, uses the master modport.
// Optional build macro VGA_SYNC_RGB_BLANK_EN adds the rgb_in/rgb_out pair.
interface vga_sync_gen_if;
    logic [9:0] cuenta_h;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_tick;
`ifdef VGA_SYNC_RGB_BLANK_EN
    logic [7:0] rgb_in;
    logic [7:0] rgb_out;
`endif

    modport master (
        output cuenta_h,
`ifdef VGA_SYNC_RGB_BLANK_EN
        output rgb_in,
        input  rgb_out,
`endif
        input  hsync,
        input  vsync,
        input  video_on,
        input  pixel_x,
        input  pixel_y,
        input  frame_tick
    );

    modport slave (
        input  cuenta_h,
`ifdef VGA_SYNC_RGB_BLANK_EN
        input  rgb_in,
        output rgb_out,
`endif
        output hsync,
        output vsync,
        output video_on,
        output pixel_x,
        output pixel_y,
        output frame_tick
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA sync stage.
//
// This stage follows the free-running horizontal counter. It keeps the
// vertical line counter, and it produces registered hsync, vsync, video_on,
// pixel coordinates and an end-of-frame pulse.
//
// Every output is registered with one cycle of latency. Each output is
// computed from the horizontal count and the vertical count as they were
// before the update. For this reason, the last pixel of a line is still
// reported with the old line number.
//
// Optional build macro VGA_SYNC_RGB_BLANK_EN adds an rgb_out port. rgb_out
// carries rgb_in inside the visible area and is forced to 8'h00 outside it.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_MAX     = 800,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_MAX     = 524,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic          Clk,
    input  logic          reset,
    vga_sync_gen_if.slave bus
);

    // The parameter sums must fit in 10 bits. No hardware checks this.
    localparam logic [9:0] H_VIS_L  = 10'(H_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_MAX_L  = 10'(H_MAX);
    localparam logic [9:0] V_VIS_L  = 10'(V_VISIBLE);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_MAX_L  = 10'(V_MAX);

    logic [9:0] cuenta_v;
    logic       h_sync_act;
    logic       v_sync_act;
    logic       visible;
    logic       line_end;
    logic       frame_end;

    // Timing decode from the current horizontal count and the pre-update line.
    always_comb begin
        h_sync_act = (bus.cuenta_h >= HS_START) && (bus.cuenta_h < HS_END);
        v_sync_act = (cuenta_v >= VS_START) && (cuenta_v < VS_END);
        visible    = (bus.cuenta_h < H_VIS_L) && (cuenta_v < V_VIS_L);
        line_end   = (bus.cuenta_h == H_MAX_L);
        frame_end  = line_end && (cuenta_v == V_MAX_L);
    end

    // Vertical line counter. It moves only when the last horizontal count is
    // seen. Any value at or beyond the last line wraps to 0, so a corrupted
    // count recovers at the next line end.
    always_ff @(posedge Clk) begin
        if (reset) begin
            cuenta_v <= '0;
        end else if (line_end) begin
            if (cuenta_v >= V_MAX_L)
                cuenta_v <= '0;
            else
                cuenta_v <= cuenta_v + 10'd1;
        end
    end

    // Registered timing outputs.
    always_ff @(posedge Clk) begin
        if (reset) begin
            bus.hsync      <= ~SYNC_POL;
            bus.vsync      <= ~SYNC_POL;
            bus.video_on   <= 1'b0;
            bus.pixel_x    <= '0;
            bus.pixel_y    <= '0;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.hsync      <= h_sync_act ? SYNC_POL : ~SYNC_POL;
            bus.vsync      <= v_sync_act ? SYNC_POL : ~SYNC_POL;
            bus.video_on   <= visible;
            bus.pixel_x    <= bus.cuenta_h;
            bus.pixel_y    <= cuenta_v;
            bus.frame_tick <= frame_end;
        end
    end

`ifdef VGA_SYNC_RGB_BLANK_EN
    // Blank the pixel data outside the visible area. This stays aligned with video_on.
    always_ff @(posedge Clk) begin
        if (reset)
            bus.rgb_out <= 8'h00;
        else
            bus.rgb_out <= visible ? bus.rgb_in : 8'h00;
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen with the default 640x480 timing.
// For each driven cycle, the driver pushes the expected output into a queue.
// A separate monitor pops from that queue one cycle later and compares.
// The bench reaches lines quickly by driving cuenta_h = 800 back to back,
// which advances one line per cycle.
module tb_vga_sync_gen;

    logic Clk = 1'b0;
    logic reset = 1'b1;
    vga_sync_gen_if bus();

    vga_sync_gen dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       vo;
        logic [9:0] px;
        logic [9:0] py;
        logic       ft;
        logic [7:0] rgb;
    } obs_t;

    obs_t exp_q[$];
    int   id_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_vec = 0;
    int   ticks_seen = 0;
    int   m_v = 0;

    localparam logic [7:0] RGB_PAT = 8'hA5;

    // Driver: apply one input on the falling edge and queue the expected response.
    task automatic drive(input logic r, input logic [9:0] h);
        obs_t e;
        @(negedge Clk);
        reset = r;
        bus.cuenta_h = h;
`ifdef VGA_SYNC_RGB_BLANK_EN
        bus.rgb_in = RGB_PAT;
`endif
        if (r) begin
            e = '{hs: 1'b1, vs: 1'b1, vo: 1'b0, px: 10'd0, py: 10'd0, ft: 1'b0, rgb: 8'h00};
            m_v = 0;
        end else begin
            e.hs  = !(h >= 10'd656 && h <= 10'd751);
            e.vs  = !(m_v == 490 || m_v == 491);
            e.vo  = (h <= 10'd639) && (m_v <= 479);
            e.px  = h;
            e.py  = 10'(m_v);
            e.ft  = (h == 10'd800) && (m_v == 524);
`ifdef VGA_SYNC_RGB_BLANK_EN
            e.rgb = e.vo ? RGB_PAT : 8'h00;
`else
            e.rgb = 8'h00;
`endif
            if (h == 10'd800)
                m_v = (m_v == 524) ? 0 : m_v + 1;
        end
        exp_q.push_back(e);
        id_q.push_back(n_vec);
        n_vec++;
    endtask

    task automatic full_line();
        for (int i = 0; i <= 800; i++)
            drive(1'b0, 10'(i));
    endtask

    task automatic advance_to(input int line);
        while (m_v != line)
            drive(1'b0, 10'd800);
    endtask

    // Monitor: sample just after each rising edge and check against the queue head.
    initial begin
        obs_t e;
        obs_t g;
        int   id;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                g.hs = bus.hsync;
                g.vs = bus.vsync;
                g.vo = bus.video_on;
                g.px = bus.pixel_x;
                g.py = bus.pixel_y;
                g.ft = bus.frame_tick;
`ifdef VGA_SYNC_RGB_BLANK_EN
                g.rgb = bus.rgb_out;
`else
                g.rgb = 8'h00;
`endif
                if (g.ft === 1'b1)
                    ticks_seen++;
                n_cmp++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL vec%0d: got hs=%b vs=%b vo=%b x=%0d y=%0d ft=%b rgb=%h, expected hs=%b vs=%b vo=%b x=%0d y=%0d ft=%b rgb=%h",
                             id, g.hs, g.vs, g.vo, g.px, g.py, g.ft, g.rgb,
                             e.hs, e.vs, e.vo, e.px, e.py, e.ft, e.rgb);
                end
            end
        end
    end

    initial begin
        bus.cuenta_h = 10'd0;
`ifdef VGA_SYNC_RGB_BLANK_EN
        bus.rgb_in = RGB_PAT;
`endif
        // Hold reset for 3 cycles with arbitrary counts, including 800, which must not advance the line.
        drive(1'b1, 10'd123);
        drive(1'b1, 10'd800);
        drive(1'b1, 10'd1000);

        // Lines 0 and 1: the visible window and the hsync window.
        full_line();
        full_line();

        // Vsync lines and the lines around them.
        advance_to(489);
        for (int l = 0; l < 4; l++)
            full_line();

        // Last line of the frame, the tick, then the wrap to line 0.
        advance_to(524);
        full_line();
        for (int i = 0; i <= 20; i++)
            drive(1'b0, 10'(i));

        // Out-of-range and backward horizontal counts: the line does not advance.
        drive(1'b0, 10'd801);
        drive(1'b0, 10'd900);
        drive(1'b0, 10'd1023);
        drive(1'b0, 10'd700);
        drive(1'b0, 10'd5);
        drive(1'b0, 10'd639);
        drive(1'b0, 10'd640);

        // One-cycle reset in the middle of line 300, then timing restarts from line 0.
        advance_to(300);
        for (int i = 0; i < 400; i++)
            drive(1'b0, 10'(i));
        drive(1'b1, 10'd400);
        for (int i = 401; i <= 800; i++)
            drive(1'b0, 10'(i));
        full_line();
        advance_to(490);
        full_line();
        full_line();
        advance_to(524);
        drive(1'b0, 10'd800);
        drive(1'b0, 10'd800);
        drive(1'b0, 10'd0);

        // Let the monitor drain the queue, up to a fixed cycle budget.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(negedge Clk);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d responses left unchecked, required 0", exp_q.size());
        end
        n_cmp++;
        if (ticks_seen != 2) begin
            n_bad++;
            $display("FAIL frame_ticks: saw %0d, required 2", ticks_seen);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
